// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters.
// Two-stage pipeline: input register, then registered result tagged to its requester.

module alu (
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_out,
  output logic        o_zero
);
  always_comb begin
    o_out = 32'd0;
    case (i_op)
      4'd0:    o_out = i_a & i_b;
      4'd1:    o_out = i_a | i_b;
      4'd2:    o_out = i_a + i_b;
      4'd6:    o_out = i_a - i_b;
      default: o_out = 32'd0;
    endcase
  end

  assign o_zero = (o_out == 32'd0);
endmodule

module alu_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req0_valid,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_out,
  output logic        rsp_zero
);
  logic        r_last;
  logic        r_s1_valid;
  logic        r_s1_id;
  logic [3:0]  r_s1_op;
  logic [31:0] r_s1_a;
  logic [31:0] r_s1_b;
  logic        r_s2_valid;
  logic        r_s2_id;
  logic [31:0] r_rsp_out;
  logic        r_rsp_zero;

  logic        w_rdy0;
  logic        w_rdy1;
  logic        w_acc;
  logic        w_id;
  logic [31:0] w_alu_out;
  logic        w_alu_zero;

  // On contention the requester that was not granted last wins.
  assign w_rdy0 = !rst && !flush && req0_valid && (!req1_valid || r_last);
  assign w_rdy1 = !rst && !flush && req1_valid && (!req0_valid || !r_last);
  assign w_acc  = w_rdy0 || w_rdy1;
  assign w_id   = w_rdy1;

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;

  alu u_alu (
    .i_op   (r_s1_op),
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .o_out  (w_alu_out),
    .o_zero (w_alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_s1_valid <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_op    <= 4'd0;
      r_s1_a     <= 32'd0;
      r_s1_b     <= 32'd0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= 1'b0;
      r_rsp_out  <= 32'd0;
      r_rsp_zero <= 1'b0;
    end else begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_last  <= w_id;
        r_s1_id <= w_id;
        r_s1_op <= w_id ? req1_op : req0_op;
        r_s1_a  <= w_id ? req1_a  : req0_a;
        r_s1_b  <= w_id ? req1_b  : req0_b;
      end
      // Flush kills the op sitting in stage 1 before it can respond.
      r_s2_valid <= r_s1_valid && !flush;
      r_s2_id    <= r_s1_id;
      if (r_s1_valid) begin
        r_rsp_out  <= w_alu_out;
        r_rsp_zero <= w_alu_zero;
      end
    end
  end

  assign rsp0_valid = r_s2_valid && !r_s2_id;
  assign rsp1_valid = r_s2_valid &&  r_s2_id;
  assign rsp_out    = r_rsp_out;
  assign rsp_zero   = r_rsp_zero;
endmodule

// File: tb/tb_alu_arb.sv
// Randomized scoreboard bench for alu_arb: a stimulus process predicts grants and
// queues expected responses; an independent monitor pops and checks them.

module tb_alu_arb;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_out;
  logic        rsp_zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit m_last = 1'b1;
  bit done = 1'b0;

  typedef struct {
    int          due;
    bit          id;
    logic [31:0] out;
    bit          zero;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arb dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      default: return 32'd0;
    endcase
  endfunction

  // One cycle of stimulus: drive, predict grant at mid-cycle, update the model.
  task automatic step(input bit r, input bit f,
                      input bit v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                      input bit v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                      output bit acc0, output bit acc1);
    bit e0, e1;
    exp_t e;
    rst = r; flush = f;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    @(negedge clk);
    e0 = !r && !f && v0 && (!v1 || m_last == 1'b1);
    e1 = !r && !f && v1 && (!v0 || m_last == 1'b0);
    checks++;
    if (req0_ready !== e0 || req1_ready !== e1) begin
      errors++;
      $display("FAIL ready cyc=%0d got r0=%b r1=%b want r0=%b r1=%b", cyc, req0_ready, req1_ready, e0, e1);
    end
    if (r || f) begin
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      if (r) m_last = 1'b1;
    end else if (e0 || e1) begin
      e.due  = cyc + 2;
      e.id   = e1;
      e.out  = e1 ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
      e.zero = (e.out == 32'd0);
      sb.push_back(e);
      m_last = e1;
    end
    acc0 = e0; acc1 = e1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: independent of stimulus, compares every presented response.
  initial begin : monitor
    bit prev_rst;
    exp_t e;
    prev_rst = 1'b1;
    while (!done) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_rsp cyc=%0d got no pulse want id=%0d due=%0d", cyc, e.id, e.due);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        checks++;
        if (rsp0_valid !== !e.id || rsp1_valid !== e.id || rsp_out !== e.out || rsp_zero !== e.zero) begin
          errors++;
          $display("FAIL rsp cyc=%0d got v0=%b v1=%b out=%h z=%b want id=%0d out=%h z=%b",
                   cyc, rsp0_valid, rsp1_valid, rsp_out, rsp_zero, e.id, e.out, e.zero);
        end
      end else begin
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
          errors++;
          $display("FAIL spurious_rsp cyc=%0d got v0=%b v1=%b want 0 0", cyc, rsp0_valid, rsp1_valid);
        end
      end
      if (prev_rst) begin
        checks++;
        if (rsp_out !== 32'd0 || rsp_zero !== 1'b0) begin
          errors++;
          $display("FAIL reset_out cyc=%0d got out=%h z=%b want 00000000 0", cyc, rsp_out, rsp_zero);
        end
      end
      prev_rst = rst;
    end
  end

  initial begin : stim
    bit a0, a1;
    bit p0, p1, v0, v1, r, f;
    logic [3:0]  o0, o1;
    logic [31:0] x0, y0, x1, y1;
    logic [3:0]  ops [4];
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd6;

    rst = 1'b1; flush = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    #1;
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);

    // Single op from req0, then idle until it returns
    step(0, 0, 1, 4'd0, 32'h0000ffff, 32'hffff0000, 0, 0, 0, 0, a0, a1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);

    // req1 streams or/add/sub back-to-back
    step(0, 0, 0, 0, 0, 0, 1, 4'd1, 32'h0000ffff, 32'hffff0000, a0, a1);
    step(0, 0, 0, 0, 0, 0, 1, 4'd2, 32'h0000ffff, 32'hffff0000, a0, a1);
    step(0, 0, 0, 0, 0, 0, 1, 4'd6, 32'h0000ffff, 32'hffff0000, a0, a1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);

    // Continuous contention from reset: grants alternate 0,1,0,1
    step(1, 0, 1, 4'd2, 32'd1, 32'd1, 1, 4'd6, 32'd5, 32'd5, a0, a1);
    repeat (4) step(0, 0, 1, 4'd2, 32'd1, 32'd1, 1, 4'd6, 32'd5, 32'd5, a0, a1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);

    // Flush the cycle after an accept; contention afterwards follows old pointer
    step(0, 0, 1, 4'd2, 32'd7, 32'd8, 0, 0, 0, 0, a0, a1);
    step(0, 1, 1, 4'd2, 32'd9, 32'd9, 1, 4'd1, 32'd3, 32'd4, a0, a1);
    step(0, 0, 1, 4'd2, 32'd9, 32'd9, 1, 4'd1, 32'd3, 32'd4, a0, a1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);

    // Reset with ops in flight, then contention goes to req0
    step(0, 0, 1, 4'd2, 32'd1, 32'd2, 1, 4'd2, 32'd3, 32'd4, a0, a1);
    step(0, 0, 1, 4'd2, 32'd1, 32'd2, 1, 4'd2, 32'd3, 32'd4, a0, a1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
    step(0, 0, 1, 4'd0, 32'hf0f0f0f0, 32'hffffffff, 1, 4'd1, 32'd0, 32'd0, a0, a1);
    step(0, 0, 1, 4'd0, 32'hf0f0f0f0, 32'hffffffff, 1, 4'd1, 32'd0, 32'd0, a0, a1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);

    // Randomized traffic with held operands, drops, flushes and resets
    p0 = 0; p1 = 0; o0 = 0; o1 = 0; x0 = 0; y0 = 0; x1 = 0; y1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!p0 && $urandom_range(2) != 0) begin
        p0 = 1; o0 = ops[$urandom_range(3)]; x0 = $urandom;
        y0 = ($urandom_range(3) == 0) ? x0 : $urandom;
      end
      if (!p1 && $urandom_range(2) != 0) begin
        p1 = 1; o1 = ops[$urandom_range(3)]; x1 = $urandom;
        y1 = ($urandom_range(3) == 0) ? x1 : $urandom;
      end
      v0 = p0 && ($urandom_range(9) != 0);
      v1 = p1 && ($urandom_range(9) != 0);
      r = ($urandom_range(59) == 0);
      f = ($urandom_range(19) == 0);
      step(r, f, v0, o0, x0, y0, v1, o1, x1, y1, a0, a1);
      if (a0) p0 = 0;
      if (a1) p1 = 0;
    end
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending responses want 0", sb.size());
    end
    done = 1'b1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arb.md
# alu_arb

Two-requester arbiter and pipeline wrapper that shares a single 32-bit `alu` instance, for example between PC/address computation and execute. Each cycle it grants at most one requester by round-robin and registers that requester's operation into an input stage. The shared `alu` evaluates the input stage, and the block registers the result and returns it, tagged to the originating requester, two cycles after acceptance. Throughput is one operation per cycle.

## Interface
- No parameters. Width is fixed at 32 to match `alu`. Op encoding is the `alu` 4-bit code: 0 and, 1 or, 2 add, 6 sub.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous; kills in-flight ops; blocks acceptance this cycle
- req0_valid  in  1  requester 0 has an op
- req0_op  in  4  requester 0 ALU op
- req0_a  in  32  requester 0 operand i1
- req0_b  in  32  requester 0 operand i2
- req0_ready  out  1  combinational grant to requester 0
- req1_valid / req1_op / req1_a / req1_b / req1_ready  same as requester 0, for requester 1
- rsp0_valid  out  1  one-cycle pulse: result belongs to requester 0
- rsp1_valid  out  1  one-cycle pulse: result belongs to requester 1
- rsp_out  out  32  registered `alu` out
- rsp_zero  out  1  registered `alu` zero (rsp_out == 0)

## Operation
- Handshake: an op is accepted on a rising edge where reqN_valid && reqN_ready.
  - After asserting valid, a requester holds op/a/b stable until accepted.
  - There is no backpressure on responses; a requester must always sink the rsp pulse.
- Grant (combinational from valid, pointer, rst, flush):
  - If rst or flush is high, both readies are 0.
  - If only one valid is high, that requester gets ready.
  - If both valids are high, the requester not granted last gets ready.
  - At most one ready is high per cycle.
- Round-robin pointer `last` (1 bit):
  - Updates to the granted index on each accept.
  - Unchanged on idle cycles.
  - Reset value is 1, so requester 0 wins the first contention.
- Stage 1 (input register):
  - On accept: s1_valid=1, s1_id=granted index, s1_op/a/b=granted fields.
  - Otherwise: s1_valid=0, and the data fields hold their values.
- The `alu` is instantiated once, driven by s1_op/a/b.
- Stage 2 (output register):
  - s2_valid=s1_valid and s2_id=s1_id.
  - rsp_out/rsp_zero load from `alu` only when s1_valid=1; otherwise they hold.
- rspN_valid = s2_valid && s2_id==N.
- Ops are passed to `alu` unchanged. Codes outside {0,1,2,6} produce whatever `alu` returns; the arbiter does not check them.
- Flush:
  - Clears s1_valid and s2_valid on the same edge.
  - Any result already presented in the flush cycle is still visible that cycle.
  - No op is accepted in the flush cycle.
  - `last` is not changed.
- Reset clears `last` to 1 (as stated above) and clears s1/s2 valids, data and ids to 0. This also applies mid-operation: in-flight ops are lost and no response pulses.

## Timing
- Reset values: req0_ready=req1_ready=0 while rst=1; rsp0_valid=rsp1_valid=0; rsp_out=0; rsp_zero=0. The internal zero flag after reset is 0 (not the `alu` flag).
- Latency:
  - Op accepted at edge N → stage 1 valid from edge N to N+1.
  - The result is visible on rsp_* and rspN_valid from edge N+1 to N+2, i.e. the cycle after stage 1.
  - Equivalently, response comes 2 edges after the valid/ready cycle begins.
- Back-to-back accepts give back-to-back responses in acceptance order.
- A requester whose valid stays high is not granted on consecutive cycles while the other is also valid. Under continuous contention the grants alternate 0,1,0,1.
- Valid dropping without acceptance is legal and leaves no state effect.

## Test plan
- Single op from req0: op=0, a=0000ffff, b=ffff0000 → ready0=1 same cycle; two cycles later rsp0_valid=1, rsp_out=00000000, rsp_zero=1, rsp1_valid=0.
- req1 streams ops 1,2,6 on the same operands, back-to-back → three consecutive rsp1 pulses with out ffffffff/z0, ffffffff/z0, 0001ffff/z0.
- Both valid continuously from reset, req0 op=2 (a=1, b=1), req1 op=6 (a=5, b=5) → grants 0,1,0,1; responses alternate 00000002/z0 and 00000000/z1.
- Flush asserted the cycle after an accept → that op never responds, no accept happens during flush, and the next contention grant still follows the pre-flush pointer.
- rst asserted with two ops in flight → no rsp pulses; outputs 0 next cycle; the first contention after release goes to req0.
- req0 valid with ready low (req1 won), operands held → accepted next cycle, and the response carries the held values.
